// File: rtl/imm_ext_pipe.sv
// Immediate extension stage with a 2-entry in-order result buffer.
// Results are computed at accept time; the head entry is presented from a registered copy.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic             err_sticky
);

  localparam int PAD = OUT_W - IN_W;

  localparam logic [2:0] MODE_SEXT = 3'd0;
  localparam logic [2:0] MODE_ZEXT = 3'd1;
  localparam logic [2:0] MODE_LUI  = 3'd2;
  localparam logic [2:0] MODE_BR   = 3'd3;
  localparam logic [2:0] MODE_JMP  = 3'd4;

  logic [OUT_W-1:0] r_data [2];
  logic             r_err  [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_err;
  logic             r_sticky;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_result;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  logic             w_head_next;
  logic             w_bypass;
  logic [1:0]       w_count_next;

  always_comb begin
    w_sext    = {{PAD{imm[IN_W-1]}}, imm};
    w_zext    = {{PAD{1'b0}}, imm};
    w_result  = '0;
    w_illegal = 1'b0;
    case (mode)
      MODE_SEXT: w_result = w_sext;
      MODE_ZEXT: w_result = w_zext;
      MODE_LUI:  w_result = {imm, {PAD{1'b0}}};
      MODE_BR:   w_result = w_sext << 2;
      MODE_JMP:  w_result = w_zext << 2;
      default:   w_illegal = 1'b1;
    endcase
  end

  assign in_ready   = (r_count != 2'd2);
  assign out_valid  = (r_count != 2'd0);
  assign out_data   = r_out_data;
  assign out_err    = r_out_err;
  assign err_sticky = r_sticky;

  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign w_head_next = r_head ^ w_pop;
  // The entry becoming head this edge is the one being written right now
  assign w_bypass    = w_push && (r_tail == w_head_next);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data[0]  <= '0;
      r_data[1]  <= '0;
      r_err[0]   <= 1'b0;
      r_err[1]   <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_result;
        r_err[r_tail]  <= w_illegal;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= w_count_next;
      // When the buffer drains, the output register keeps its last value
      if (w_count_next != 2'd0) begin
        r_out_data <= w_bypass ? w_result  : r_data[w_head_next];
        r_out_err  <= w_bypass ? w_illegal : r_err[w_head_next];
      end
      if (w_push && w_illegal) begin
        r_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: constant vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [2:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        err_sticky;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] imm;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } entry_t;

  vec_t   vecs [10];
  entry_t modelQ [$];
  logic   modelSticky;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm        (imm),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .err_sticky (err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference extension from the arithmetic meaning of each mode
  function automatic logic [31:0] refExt(input logic [2:0] m, input logic [15:0] v);
    longint uv;
    longint sv;
    longint r;
    uv = longint'(v);
    sv = v[15] ? uv - 65536 : uv;
    case (m)
      3'd0:    r = sv;
      3'd1:    r = uv;
      3'd2:    r = uv * 65536;
      3'd3:    r = sv * 4;
      3'd4:    r = uv * 4;
      default: r = 0;
    endcase
    r = r & 64'h0000_0000_FFFF_FFFF;
    return r[31:0];
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] im, input logic [2:0] md,
                               input logic rdy);
    in_valid  = v;
    imm       = im;
    mode      = md;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle at a negedge: compare against the model, drive, advance the model
  task automatic stepCycle(input string tag, input logic v, input logic [15:0] im,
                           input logic [2:0] md, input logic rdy);
    entry_t ent;
    logic   acc;
    logic   dlv;
    checkBit({tag, ".out_valid"}, out_valid, modelQ.size() != 0);
    checkBit({tag, ".in_ready"}, in_ready, modelQ.size() != 2);
    checkBit({tag, ".err_sticky"}, err_sticky, modelSticky);
    if (modelQ.size() != 0) begin
      checkOutput({tag, ".out_data"}, out_data, modelQ[0].d);
      checkBit({tag, ".out_err"}, out_err, modelQ[0].e);
    end
    applyStimulus(v, im, md, rdy);
    acc = v && (modelQ.size() < 2);
    dlv = rdy && (modelQ.size() > 0);
    if (dlv) void'(modelQ.pop_front());
    if (acc) begin
      ent.d = refExt(md, im);
      ent.e = (md >= 3'd5);
      modelQ.push_back(ent);
      if (ent.e) modelSticky = 1'b1;
    end
    @(negedge clk);
  endtask

  // Reset pulsed between clock edges, checked while still asserted
  task automatic pulseReset(input string tag);
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkBit({tag, ".rst_out_valid"}, out_valid, 1'b0);
    checkBit({tag, ".rst_in_ready"}, in_ready, 1'b1);
    checkBit({tag, ".rst_err_sticky"}, err_sticky, 1'b0);
    checkBit({tag, ".rst_out_err"}, out_err, 1'b0);
    checkOutput({tag, ".rst_out_data"}, out_data, 32'h0);
    modelQ.delete();
    modelSticky = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{3'd0, 16'h8000, 32'hFFFF_8000, 1'b0};
    vecs[1] = '{3'd1, 16'h8000, 32'h0000_8000, 1'b0};
    vecs[2] = '{3'd2, 16'h1234, 32'h1234_0000, 1'b0};
    vecs[3] = '{3'd3, 16'hFFFF, 32'hFFFF_FFFC, 1'b0};
    vecs[4] = '{3'd4, 16'hC001, 32'h0003_0004, 1'b0};
    vecs[5] = '{3'd0, 16'h7FFF, 32'h0000_7FFF, 1'b0};
    vecs[6] = '{3'd3, 16'h4001, 32'h0001_0004, 1'b0};
    vecs[7] = '{3'd2, 16'hFFFF, 32'hFFFF_0000, 1'b0};
    vecs[8] = '{3'd5, 16'h1234, 32'h0000_0000, 1'b1};
    vecs[9] = '{3'd7, 16'hFFFF, 32'h0000_0000, 1'b1};

    modelSticky = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b0);
    #1;
    checkBit("reset.out_valid", out_valid, 1'b0);
    checkBit("reset.in_ready", in_ready, 1'b1);
    checkOutput("reset.out_data", out_data, 32'h0);
    checkBit("reset.out_err", out_err, 1'b0);
    checkBit("reset.err_sticky", err_sticky, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].imm, vecs[i].mode, 1'b1);
      @(negedge clk);
      checkBit($sformatf("vec%0d.out_valid", i), out_valid, 1'b1);
      checkOutput($sformatf("vec%0d.out_data", i), out_data, vecs[i].expData);
      checkBit($sformatf("vec%0d.out_err", i), out_err, vecs[i].expErr);
    end
    applyStimulus(1'b0, 16'h0, 3'd0, 1'b1);
    @(negedge clk);
    checkBit("table.drained", out_valid, 1'b0);
    checkBit("table.sticky", err_sticky, 1'b1);
    pulseReset("table");

    $display("[TB] backpressure A,B,C");
    stepCycle("bp", 1'b1, 16'hAAAA, 3'd0, 1'b0);
    stepCycle("bp", 1'b1, 16'hBBBB, 3'd1, 1'b0);
    checkBit("bp.in_ready_low", in_ready, 1'b0);
    stepCycle("bp", 1'b1, 16'hCCCC, 3'd2, 1'b0);
    stepCycle("bp", 1'b1, 16'hCCCC, 3'd2, 1'b0);
    checkOutput("bp.hold_A", out_data, 32'hFFFF_AAAA);
    stepCycle("bp", 1'b1, 16'hCCCC, 3'd2, 1'b1);
    stepCycle("bp", 1'b1, 16'hCCCC, 3'd2, 1'b1);
    checkOutput("bp.C", out_data, 32'hCCCC_0000);
    stepCycle("bp", 1'b0, 16'h0, 3'd0, 1'b1);
    stepCycle("bp", 1'b0, 16'h0, 3'd0, 1'b1);

    $display("[TB] streaming at count 1");
    stepCycle("st", 1'b1, 16'h0100, 3'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      stepCycle("st", 1'b1, 16'(16'h0101 + i * 16'h0111), 3'(i % 5), 1'b1);
    end
    stepCycle("st", 1'b0, 16'h0, 3'd0, 1'b1);
    stepCycle("st", 1'b0, 16'h0, 3'd0, 1'b1);

    $display("[TB] illegal mode and sticky error");
    stepCycle("err", 1'b1, 16'h7FFF, 3'd6, 1'b1);
    checkOutput("err.data", out_data, 32'h0);
    checkBit("err.flag", out_err, 1'b1);
    checkBit("err.sticky", err_sticky, 1'b1);
    stepCycle("err", 1'b1, 16'h0042, 3'd0, 1'b1);
    stepCycle("err", 1'b1, 16'h0042, 3'd2, 1'b1);
    stepCycle("err", 1'b0, 16'h0, 3'd0, 1'b1);
    checkBit("err.sticky_held", err_sticky, 1'b1);

    $display("[TB] reset with a full buffer");
    stepCycle("rst", 1'b1, 16'h1111, 3'd6, 1'b0);
    stepCycle("rst", 1'b1, 16'h2222, 3'd1, 1'b0);
    checkBit("rst.full", in_ready, 1'b0);
    pulseReset("rst");
    stepCycle("rst", 1'b0, 16'h0, 3'd0, 1'b1);
    stepCycle("rst", 1'b0, 16'h0, 3'd0, 1'b1);
    stepCycle("rst", 1'b1, 16'h8001, 3'd3, 1'b1);
    checkOutput("rst.first_accept", out_data, 32'hFFFE_0004);
    stepCycle("rst", 1'b0, 16'h0, 3'd0, 1'b1);

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      stepCycle("rnd", 1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) begin
      stepCycle("rnd", 1'b0, 16'h0, 3'd0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
